imem_sync_rom: RTL and testbench

IMEM_SYNC_ROM -- requirements
Module: imem_sync_rom

---
 rtl/imem_sync_rom.sv | 119 +++++++++++
 tb/tb_imem_sync_rom.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_sync_rom.sv
// imem_sync_rom: word-indexed instruction memory with a program-load write
// port and a one-deep registered fetch response (latency 1, back-to-back
// capable). Faulting fetches (misaligned or out of range) return FILL_WORD.
module imem_sync_rom #(
   parameter int                DATA_W    = 32,
   parameter int                DEPTH     = 64,
   parameter int                ADDR_W    = 32,
   parameter logic [DATA_W-1:0] FILL_WORD = {DATA_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [ADDR_W-1:0] addr,
   output logic              req_ready,
   output logic              rvalid,
   input  logic              rready,
   output logic [DATA_W-1:0] rdata,
   output logic              fault,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic [15:0]       fetch_cnt
);

   localparam int                IDX_W       = $clog2(DEPTH);
   localparam int                WORD_W      = ADDR_W - 2;
   localparam logic [WORD_W-1:0] DEPTH_WORDS = WORD_W'(DEPTH);

   // Storage: one synchronous read port (fetch) and one write port (load).
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              rvalid_q, rvalid_d;
   logic [DATA_W-1:0] rdata_q,  rdata_d;
   logic              fault_q,  fault_d;
   logic [15:0]       cnt_q,    cnt_d;

   logic              fire_s;
   logic              fetch_fault_s;
   logic [IDX_W-1:0]  fetch_idx_s;
   logic              ld_we_s;
   logic [IDX_W-1:0]  ld_idx_s;

   // Fetch decode: a fault is any misaligned address or word index beyond DEPTH.
   always_comb begin
      fetch_idx_s   = addr[IDX_W+1:2];
      fetch_fault_s = (addr[1:0] != 2'b00) || (addr[ADDR_W-1:2] >= DEPTH_WORDS);
   end

   // Handshake: accept when the response slot is empty or being drained; never in reset.
   always_comb begin
      if (rst) begin
         req_ready = 1'b0;
      end else begin
         req_ready = (!rvalid_q) || rready;
      end
      fire_s = req && req_ready;
   end

   // Load decode: only aligned, in-range loads outside reset reach storage.
   always_comb begin
      ld_idx_s = ld_addr[IDX_W+1:2];
      ld_we_s  = ld_en && !rst && (ld_addr[1:0] == 2'b00) &&
                 (ld_addr[ADDR_W-1:2] < DEPTH_WORDS);
   end

   // Storage write port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (ld_we_s) begin
         mem_q[ld_idx_s] <= ld_data;
      end
   end

   // Response and counter next state; the read sees pre-write data on a collision.
   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      fault_d  = fault_q;
      cnt_d    = cnt_q;
      if (fire_s) begin
         rvalid_d = 1'b1;
         fault_d  = fetch_fault_s;
         if (fetch_fault_s) begin
            rdata_d = FILL_WORD;
         end else begin
            rdata_d = mem_q[fetch_idx_s];
         end
      end else if (rvalid_q && rready) begin
         rvalid_d = 1'b0;
      end else begin
         rvalid_d = rvalid_q;
      end
      if (fire_s && (cnt_q != 16'hFFFF)) begin
         cnt_d = cnt_q + 16'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Response and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid_q <= 1'b0;
         rdata_q  <= {DATA_W{1'b0}};
         fault_q  <= 1'b0;
         cnt_q    <= 16'h0000;
      end else begin
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         fault_q  <= fault_d;
         cnt_q    <= cnt_d;
      end
   end

   assign rvalid    = rvalid_q;
   assign rdata     = rdata_q;
   assign fault     = fault_q;
   assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_imem_sync_rom.sv
// Self-checking bench for imem_sync_rom: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural model (array memory + single response slot + counter).
module tb_imem_sync_rom;

   localparam int          DATA_W = 32;
   localparam int          DEPTH  = 64;
   localparam int          ADDR_W = 32;
   localparam logic [31:0] FILL   = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic [31:0] addr = 32'd0;
   logic        req_ready;
   logic        rvalid;
   logic        rready = 1'b0;
   logic [31:0] rdata;
   logic        fault;
   logic        ld_en = 1'b0;
   logic [31:0] ld_addr = 32'd0;
   logic [31:0] ld_data = 32'd0;
   logic [15:0] fetch_cnt;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   logic [31:0] m_mem [DEPTH];
   bit          model_ok = 1'b0;
   bit          m_valid  = 1'b0;
   logic [31:0] m_data   = 32'd0;
   bit          m_fault  = 1'b0;
   int          m_cnt    = 0;

   imem_sync_rom #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .FILL_WORD(FILL)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .addr     (addr),
      .req_ready(req_ready),
      .rvalid   (rvalid),
      .rready   (rready),
      .rdata    (rdata),
      .fault    (fault),
      .ld_en    (ld_en),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data),
      .fetch_cnt(fetch_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Compare DUT against the model with the current inputs, then advance the model.
   task automatic model_step();
      bit          ready;
      int unsigned w;
      bit          bad;
      ready = !rst && (!m_valid || rready);
      if (model_ok) begin
         chk("m_req_ready", {31'd0, req_ready}, {31'd0, ready});
         chk("m_rvalid", {31'd0, rvalid}, {31'd0, m_valid});
         if (m_valid) begin
            chk("m_rdata", rdata, m_data);
            chk("m_fault", {31'd0, fault}, {31'd0, m_fault});
         end
         chk("m_fetch_cnt", {16'd0, fetch_cnt}, m_cnt);
      end
      if (rst) begin
         m_valid  = 1'b0;
         m_data   = 32'd0;
         m_fault  = 1'b0;
         m_cnt    = 0;
         model_ok = 1'b1;
      end else begin
         if (req && ready) begin
            w       = addr / 4;
            bad     = (addr % 4 != 0) || (w >= DEPTH);
            m_data  = bad ? FILL : m_mem[w];
            m_fault = bad;
            m_valid = 1'b1;
            if (m_cnt < 65535) m_cnt++;
         end else if (m_valid && rready) begin
            m_valid = 1'b0;
         end
         if (ld_en && (ld_addr % 4 == 0) && (ld_addr / 4 < DEPTH)) begin
            m_mem[ld_addr / 4] = ld_data;
         end
      end
   endtask

   // One clock: check/advance model mid-cycle, then return just after the edge.
   task automatic cyc();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req = 1'b0; ld_en = 1'b0;
   endtask

   function automatic logic [31:0] rand_addr();
      int unsigned sel;
      sel = $urandom_range(0, 9);
      if (sel < 7)      return {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
      else if (sel < 9) return 32'($urandom_range(0, 4 * DEPTH + 16));
      else              return $urandom;
   endfunction

   initial begin
      logic [15:0] cnt0;

      // reset state
      rst = 1'b1; rready = 1'b0; idle();
      cyc();
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      cyc();
      chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_fault", {31'd0, fault}, 32'd0);
      chk("rst_cnt", {16'd0, fetch_cnt}, 32'd0);
      rst = 1'b0;

      // preload every word with random content
      for (int i = 0; i < DEPTH; i++) begin
         ld_en = 1'b1; ld_addr = 32'(i * 4); ld_data = $urandom;
         cyc();
      end
      // dropped loads: misaligned and out of range
      ld_addr = 32'h0000_0102; ld_data = 32'hBAD0_0001; cyc();
      ld_addr = 32'(4 * DEPTH); ld_data = 32'hBAD0_0002; cyc();
      ld_addr = 32'h0000_0005; ld_data = 32'hBAD0_0003; cyc();
      ld_en = 1'b0;
      req = 1'b1; rready = 1'b1; addr = 32'h0; cyc();
      addr = 32'h4; cyc();
      req = 1'b0; cyc();

      // basic load then fetch
      rst = 1'b1; cyc(); rst = 1'b0;
      ld_en = 1'b1; ld_addr = 32'h4; ld_data = 32'h0080_0693; cyc();
      ld_addr = 32'h8; ld_data = 32'h00D7_0023; cyc();
      ld_en = 1'b0; rready = 1'b1;
      req = 1'b1; addr = 32'h4; cyc();
      chk("basic_rvalid0", {31'd0, rvalid}, 32'd1);
      chk("basic_rdata0", rdata, 32'h0080_0693);
      addr = 32'h8; cyc();
      chk("basic_rdata1", rdata, 32'h00D7_0023);
      chk("basic_fault1", {31'd0, fault}, 32'd0);
      chk("basic_cnt", {16'd0, fetch_cnt}, 32'd2);
      req = 1'b0; cyc();
      chk("basic_drain", {31'd0, rvalid}, 32'd0);

      // backpressure
      req = 1'b1; addr = 32'h4; rready = 1'b0; cyc();
      addr = 32'h8;
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("bp_hold_rdata", rdata, 32'h0080_0693);
         chk("bp_ready_low", {31'd0, req_ready}, 32'd0);
      end
      rready = 1'b1; #1;
      chk("bp_ready_rise", {31'd0, req_ready}, 32'd1);
      cyc();
      chk("bp_next_rdata", rdata, 32'h00D7_0023);
      req = 1'b0; cyc();

      // faults
      cnt0 = fetch_cnt;
      req = 1'b1; addr = 32'h6; cyc();
      chk("fault_mis_rdata", rdata, FILL);
      chk("fault_mis_flag", {31'd0, fault}, 32'd1);
      addr = 32'(4 * DEPTH); cyc();
      chk("fault_oor_flag", {31'd0, fault}, 32'd1);
      chk("fault_oor_rdata", rdata, FILL);
      chk("fault_cnt", {16'd0, fetch_cnt}, {16'd0, cnt0 + 16'd2});
      req = 1'b0; cyc();

      // read/write collision
      ld_en = 1'b1; ld_addr = 32'hC; ld_data = 32'h1111_1111; cyc();
      ld_data = 32'h2222_2222; req = 1'b1; addr = 32'hC; cyc();
      chk("coll_old", rdata, 32'h1111_1111);
      ld_en = 1'b0; cyc();
      chk("coll_new", rdata, 32'h2222_2222);
      req = 1'b0; cyc();

      // reset mid-operation
      req = 1'b1; addr = 32'h4; rready = 1'b0; cyc();
      chk("mid_rvalid", {31'd0, rvalid}, 32'd1);
      req = 1'b0; rst = 1'b1; cyc();
      chk("mid_rst_rvalid", {31'd0, rvalid}, 32'd0);
      chk("mid_rst_cnt", {16'd0, fetch_cnt}, 32'd0);
      rst = 1'b0; rready = 1'b1; req = 1'b1; addr = 32'h4; cyc();
      chk("mid_refetch", rdata, 32'h0080_0693);
      req = 1'b0; cyc();

      // randomized traffic
      for (int i = 0; i < 2000; i++) begin
         rst     = ($urandom_range(0, 99) == 0);
         req     = ($urandom_range(0, 3) != 0);
         rready  = ($urandom_range(0, 2) != 0);
         addr    = rand_addr();
         ld_en   = ($urandom_range(0, 3) == 0);
         ld_addr = rand_addr();
         ld_data = $urandom;
         cyc();
      end
      rst = 1'b0; idle();

      // counter saturation
      rst = 1'b1; cyc(); rst = 1'b0;
      req = 1'b1; rready = 1'b1; addr = 32'h4;
      for (int i = 0; i < 65537; i++) cyc();
      chk("sat_cnt", {16'd0, fetch_cnt}, 32'h0000_FFFF);
      req = 1'b0; cyc();
      chk("sat_hold", {16'd0, fetch_cnt}, 32'h0000_FFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
